// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: IEEE 1149.1 TAP state encodings and the TMS-driven
// next-state function, for reuse by any block that tracks a TAP controller.
package jtag_pkg;

   localparam int unsigned TAP_STATE_W = 4;

   localparam logic [TAP_STATE_W-1:0] TAP_TLR    = 4'hF;
   localparam logic [TAP_STATE_W-1:0] TAP_RTI    = 4'hC;
   localparam logic [TAP_STATE_W-1:0] TAP_SELDR  = 4'h7;
   localparam logic [TAP_STATE_W-1:0] TAP_CAPDR  = 4'h6;
   localparam logic [TAP_STATE_W-1:0] TAP_SHDR   = 4'h2;
   localparam logic [TAP_STATE_W-1:0] TAP_EX1DR  = 4'h1;
   localparam logic [TAP_STATE_W-1:0] TAP_PAUDR  = 4'h3;
   localparam logic [TAP_STATE_W-1:0] TAP_EX2DR  = 4'h0;
   localparam logic [TAP_STATE_W-1:0] TAP_UPDDR  = 4'h5;
   localparam logic [TAP_STATE_W-1:0] TAP_SELIR  = 4'h4;
   localparam logic [TAP_STATE_W-1:0] TAP_CAPIR  = 4'hE;
   localparam logic [TAP_STATE_W-1:0] TAP_SHIR   = 4'hA;
   localparam logic [TAP_STATE_W-1:0] TAP_EX1IR  = 4'h9;
   localparam logic [TAP_STATE_W-1:0] TAP_PAUIR  = 4'hB;
   localparam logic [TAP_STATE_W-1:0] TAP_EX2IR  = 4'h8;
   localparam logic [TAP_STATE_W-1:0] TAP_UPDIR  = 4'hD;

   // TAP transition taken on a TCK rising edge for the sampled TMS value
   function automatic logic [TAP_STATE_W-1:0] tap_next(input logic [TAP_STATE_W-1:0] state,
                                                       input logic tms);
      logic [TAP_STATE_W-1:0] nxt;
      nxt = TAP_TLR;
      case (state)
         TAP_TLR:   nxt = tms ? TAP_TLR   : TAP_RTI;
         TAP_RTI:   nxt = tms ? TAP_SELDR : TAP_RTI;
         TAP_SELDR: nxt = tms ? TAP_SELIR : TAP_CAPDR;
         TAP_CAPDR: nxt = tms ? TAP_EX1DR : TAP_SHDR;
         TAP_SHDR:  nxt = tms ? TAP_EX1DR : TAP_SHDR;
         TAP_EX1DR: nxt = tms ? TAP_UPDDR : TAP_PAUDR;
         TAP_PAUDR: nxt = tms ? TAP_EX2DR : TAP_PAUDR;
         TAP_EX2DR: nxt = tms ? TAP_UPDDR : TAP_SHDR;
         TAP_UPDDR: nxt = tms ? TAP_SELDR : TAP_RTI;
         TAP_SELIR: nxt = tms ? TAP_TLR   : TAP_CAPIR;
         TAP_CAPIR: nxt = tms ? TAP_EX1IR : TAP_SHIR;
         TAP_SHIR:  nxt = tms ? TAP_EX1IR : TAP_SHIR;
         TAP_EX1IR: nxt = tms ? TAP_UPDIR : TAP_PAUIR;
         TAP_PAUIR: nxt = tms ? TAP_EX2IR : TAP_PAUIR;
         TAP_EX2IR: nxt = tms ? TAP_UPDIR : TAP_SHIR;
         TAP_UPDIR: nxt = tms ? TAP_SELDR : TAP_RTI;
         default:   nxt = TAP_TLR;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/jtag_tms_sniffer_if.sv
// Control/status bundle between a TMS sniffer and its owner (pattern driver
// self-check or trace trigger logic).
interface jtag_tms_sniffer_if #(
   parameter int unsigned W = 16
);
   logic [W-1:0] pattern;
   logic         arm;
   logic         armed;
   logic         match;
   logic         matched;
   logic [7:0]   bit_count;
   logic [3:0]   tap_state;
   logic         tck_edge;

   modport master (
      output pattern, arm,
      input  armed, match, matched, bit_count, tap_state, tck_edge
   );

   modport slave (
      input  pattern, arm,
      output armed, match, matched, bit_count, tap_state, tck_edge
   );
endinterface

// File: rtl/jtag_line_filter.sv
// Brings one asynchronous JTAG line into clk: 2-flop synchronizer, plus an
// optional deglitch stage when JTAG_SNIFF_DEGLITCH_EN is defined.
module jtag_line_filter #(
   parameter int unsigned pFILTER_LEN = 3,
   parameter logic        pRESET_VAL  = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic line_in,
   output logic line_s
);

   localparam int unsigned CNT_W = 4;

   if (pFILTER_LEN < 2 || pFILTER_LEN > 15) begin : g_bad_filter_len
      $error("jtag_line_filter: pFILTER_LEN out of range 2..15");
   end

   logic sync1_q;
   logic sync2_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= pRESET_VAL;
         sync2_q <= pRESET_VAL;
      end else begin
         sync1_q <= line_in;
         sync2_q <= sync1_q;
      end
   end

`ifdef JTAG_SNIFF_DEGLITCH_EN
   logic             filt_q;
   logic [CNT_W-1:0] cnt_q;

   // Output follows the line only once it has disagreed for pFILTER_LEN samples in a row
   always_ff @(posedge clk) begin
      if (reset) begin
         filt_q <= pRESET_VAL;
         cnt_q  <= '0;
      end else if (sync2_q == filt_q) begin
         cnt_q <= '0;
      end else if (cnt_q == CNT_W'(pFILTER_LEN - 1)) begin
         filt_q <= sync2_q;
         cnt_q  <= '0;
      end else begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign line_s = filt_q;
`else
   assign line_s = sync2_q;
`endif

endmodule

// File: rtl/jtag_tms_sniffer.sv
// Passive TCK/TMS observer: tracks the TAP state and flags a one-shot match of
// the last pPATTERN_WIDTH TMS bits. Optional input deglitch: JTAG_SNIFF_DEGLITCH_EN.
module jtag_tms_sniffer
   import jtag_pkg::*;
#(
   parameter int unsigned pPATTERN_WIDTH = 16,
   parameter int unsigned pFILTER_LEN    = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tck_in,
   input  logic               tms_in,
   jtag_tms_sniffer_if.slave  bus
);

   localparam int unsigned W     = pPATTERN_WIDTH;
   localparam int unsigned CNT_W = 8;

   if (W < 1 || W > 64) begin : g_bad_width
      $error("jtag_tms_sniffer: pPATTERN_WIDTH out of range 1..64");
   end

   logic tck_s;
   logic tms_s;
   logic tck_prev_q;
   logic edge_c;

   jtag_line_filter #(.pFILTER_LEN(pFILTER_LEN), .pRESET_VAL(1'b0)) u_tck_filter (
      .clk     (clk),
      .reset   (reset),
      .line_in (tck_in),
      .line_s  (tck_s)
   );

   jtag_line_filter #(.pFILTER_LEN(pFILTER_LEN), .pRESET_VAL(1'b1)) u_tms_filter (
      .clk     (clk),
      .reset   (reset),
      .line_in (tms_in),
      .line_s  (tms_s)
   );

   assign edge_c = tck_s & ~tck_prev_q;

   logic                   armed_q,     armed_n;
   logic                   match_q,     match_n;
   logic                   matched_q,   matched_n;
   logic [CNT_W-1:0]       bit_count_q, bit_count_n;
   logic [TAP_STATE_W-1:0] tap_q,       tap_n;
   logic                   tck_edge_q,  tck_edge_n;
   logic [W-1:0]           sr_q,        sr_n;

   always_ff @(posedge clk) begin
      if (reset) begin
         tck_prev_q  <= 1'b0;
         armed_q     <= 1'b0;
         match_q     <= 1'b0;
         matched_q   <= 1'b0;
         bit_count_q <= '0;
         tap_q       <= TAP_TLR;
         tck_edge_q  <= 1'b0;
         sr_q        <= '0;
      end else begin
         tck_prev_q  <= tck_s;
         armed_q     <= armed_n;
         match_q     <= match_n;
         matched_q   <= matched_n;
         bit_count_q <= bit_count_n;
         tap_q       <= tap_n;
         tck_edge_q  <= tck_edge_n;
         sr_q        <= sr_n;
      end
   end

   // tck_edge_q marks the cycle right after a history update, so the compare sees fresh sr/bit_count
   always_comb begin
      armed_n     = armed_q;
      match_n     = 1'b0;
      matched_n   = matched_q;
      bit_count_n = bit_count_q;
      tap_n       = tap_q;
      tck_edge_n  = edge_c;
      sr_n        = sr_q;

      if (edge_c) begin
         tap_n = tap_next(tap_q, tms_s);
      end

      if (bus.arm) begin
         armed_n     = 1'b1;
         matched_n   = 1'b0;
         bit_count_n = '0;
         sr_n        = '0;
      end else begin
         if (edge_c && armed_q) begin
            sr_n = (sr_q >> 1) | (W'(tms_s) << (W - 1));
            if (bit_count_q != '1) begin
               bit_count_n = bit_count_q + CNT_W'(1);
            end
         end
         if (tck_edge_q && armed_q && (bit_count_q >= CNT_W'(W)) && (sr_q == bus.pattern)) begin
            match_n   = 1'b1;
            matched_n = 1'b1;
            armed_n   = 1'b0;
         end
      end
   end

   assign bus.armed     = armed_q;
   assign bus.match     = match_q;
   assign bus.matched   = matched_q;
   assign bus.bit_count = bit_count_q;
   assign bus.tap_state = tap_q;
   assign bus.tck_edge  = tck_edge_q;

endmodule

// File: tb/tb_jtag_tms_sniffer.sv
// Directed self-checking bench for jtag_tms_sniffer (default build, no deglitch).
module tb_jtag_tms_sniffer;

   localparam int unsigned W = 16;

   logic clk    = 1'b0;
   logic reset  = 1'b1;
   logic tck_in = 1'b0;
   logic tms_in = 1'b1;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int match_cnt = 0;
   int edge_cnt = 0;
   int match_cyc = 0;
   int edge_cyc = 0;

   jtag_tms_sniffer_if #(.W(W)) bus ();

   jtag_tms_sniffer #(.pPATTERN_WIDTH(W), .pFILTER_LEN(3)) dut (
      .clk    (clk),
      .reset  (reset),
      .tck_in (tck_in),
      .tms_in (tms_in),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitor, sampled on the inactive edge
   always @(negedge clk) begin
      if (bus.match === 1'b1) begin
         match_cnt = match_cnt + 1;
         match_cyc = cyc;
      end
      if (bus.tck_edge === 1'b1) begin
         edge_cnt = edge_cnt + 1;
         edge_cyc = cyc;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tck_bit(input logic b);
      tms_in = b;
      repeat (4) tick();
      tck_in = 1'b1;
      repeat (4) tick();
      tck_in = 1'b0;
   endtask

   task automatic send_word(input logic [15:0] w);
      for (int i = 0; i < 16; i++) tck_bit(w[i]);
   endtask

   task automatic pulse_arm();
      bus.arm = 1'b1;
      tick();
      bus.arm = 1'b0;
   endtask

   task automatic clear_mon();
      match_cnt = 0;
      edge_cnt  = 0;
      match_cyc = 0;
      edge_cyc  = 0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      clear_mon();
      repeat (100) tick();
      checks++; if (bus.tap_state !== 4'hF) begin errors++; $display("FAIL reset_tap: got %h expected %h", bus.tap_state, 4'hF); end
      checks++; if (bus.bit_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.bit_count); end
      checks++; if (bus.armed !== 1'b0) begin errors++; $display("FAIL reset_armed: got %b expected 0", bus.armed); end
      checks++; if (bus.matched !== 1'b0) begin errors++; $display("FAIL reset_matched: got %b expected 0", bus.matched); end
      checks++; if (match_cnt !== 0) begin errors++; $display("FAIL idle_match: got %0d pulses expected 0", match_cnt); end
      checks++; if (edge_cnt !== 0) begin errors++; $display("FAIL idle_edge: got %0d strobes expected 0", edge_cnt); end
   endtask

   task automatic test_match();
      bus.pattern = 16'hE79E;
      pulse_arm();
      checks++; if (bus.armed !== 1'b1) begin errors++; $display("FAIL arm_set: got %b expected 1", bus.armed); end
      clear_mon();
      send_word(16'hE79E);
      repeat (3) tick();
      checks++; if (match_cnt !== 1) begin errors++; $display("FAIL match_pulses: got %0d expected 1", match_cnt); end
      checks++; if (match_cyc - edge_cyc !== 1) begin errors++; $display("FAIL match_latency: got %0d expected 1 cycle after tck_edge", match_cyc - edge_cyc); end
      checks++; if (edge_cnt !== 16) begin errors++; $display("FAIL edge_strobes: got %0d expected 16", edge_cnt); end
      checks++; if (bus.matched !== 1'b1) begin errors++; $display("FAIL matched_set: got %b expected 1", bus.matched); end
      checks++; if (bus.armed !== 1'b0) begin errors++; $display("FAIL armed_clear: got %b expected 0", bus.armed); end
      checks++; if (bus.bit_count !== 8'd16) begin errors++; $display("FAIL match_count: got %0d expected 16", bus.bit_count); end
   endtask

   task automatic test_tap();
      logic       bits [9]   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [3:0] exp_st [9] = '{4'h1, 4'h5, 4'h7, 4'h4, 4'hF, 4'hC, 4'h7, 4'h6, 4'h2};
      bus.pattern = 16'h0000;
      repeat (5) tck_bit(1'b1);
      tck_bit(1'b0); tck_bit(1'b1); tck_bit(1'b0); tck_bit(1'b0);
      checks++; if (bus.tap_state !== 4'h2) begin errors++; $display("FAIL tap_to_shdr: got %h expected 2", bus.tap_state); end
      pulse_arm();
      for (int i = 0; i < 9; i++) begin
         tck_bit(bits[i]);
         checks++; if (bus.tap_state !== exp_st[i]) begin errors++; $display("FAIL tap_step%0d: got %h expected %h", i, bus.tap_state, exp_st[i]); end
      end
      checks++; if (bus.armed !== 1'b1) begin errors++; $display("FAIL tap_armed: got %b expected 1", bus.armed); end
      checks++; if (bus.bit_count !== 8'd9) begin errors++; $display("FAIL tap_count: got %0d expected 9", bus.bit_count); end
   endtask

   task automatic test_sliding();
      bus.pattern = 16'hE79E;
      pulse_arm();
      clear_mon();
      tck_bit(1'b1); tck_bit(1'b0); tck_bit(1'b1);
      send_word(16'hE79E);
      repeat (3) tick();
      checks++; if (match_cnt !== 1) begin errors++; $display("FAIL slide_match: got %0d pulses expected 1", match_cnt); end
      checks++; if (bus.bit_count !== 8'd19) begin errors++; $display("FAIL slide_count: got %0d expected 19", bus.bit_count); end
      checks++; if (bus.matched !== 1'b1) begin errors++; $display("FAIL slide_matched: got %b expected 1", bus.matched); end

      bus.pattern = 16'hE71E;
      pulse_arm();
      clear_mon();
      tck_bit(1'b1); tck_bit(1'b0); tck_bit(1'b1);
      send_word(16'hE79E);
      repeat (3) tick();
      checks++; if (match_cnt !== 0) begin errors++; $display("FAIL flip_match: got %0d pulses expected 0", match_cnt); end
      checks++; if (bus.bit_count !== 8'd19) begin errors++; $display("FAIL flip_count: got %0d expected 19", bus.bit_count); end
      checks++; if (bus.matched !== 1'b0) begin errors++; $display("FAIL flip_matched: got %b expected 0", bus.matched); end
      checks++; if (bus.armed !== 1'b1) begin errors++; $display("FAIL flip_armed: got %b expected 1", bus.armed); end
   endtask

   task automatic test_arm_on_edge();
      bus.pattern = 16'h0000;
      repeat (5) tck_bit(1'b1);
      bus.pattern = 16'hE79E;
      tms_in = 1'b0;
      repeat (4) tick();
      tck_in = 1'b1;
      tick();
      tick();
      bus.arm = 1'b1;
      tick();
      bus.arm = 1'b0;
      tick();
      tck_in = 1'b0;
      repeat (4) tick();
      checks++; if (bus.bit_count !== 8'd0) begin errors++; $display("FAIL coinc_count: got %0d expected 0", bus.bit_count); end
      checks++; if (bus.armed !== 1'b1) begin errors++; $display("FAIL coinc_armed: got %b expected 1", bus.armed); end
      checks++; if (bus.tap_state !== 4'hC) begin errors++; $display("FAIL coinc_tap: got %h expected C", bus.tap_state); end
      clear_mon();
      send_word(16'hE79E);
      repeat (3) tick();
      checks++; if (match_cnt !== 1) begin errors++; $display("FAIL coinc_match: got %0d pulses expected 1", match_cnt); end
      checks++; if (bus.bit_count !== 8'd16) begin errors++; $display("FAIL coinc_after_count: got %0d expected 16", bus.bit_count); end
   endtask

   task automatic test_reset_mid();
      logic [15:0] w;
      w = 16'hE79E;
      bus.pattern = w;
      pulse_arm();
      for (int i = 0; i < 8; i++) tck_bit(w[i]);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (bus.tap_state !== 4'hF) begin errors++; $display("FAIL rst_mid_tap: got %h expected F", bus.tap_state); end
      checks++; if (bus.bit_count !== 8'd0) begin errors++; $display("FAIL rst_mid_count: got %0d expected 0", bus.bit_count); end
      checks++; if (bus.armed !== 1'b0) begin errors++; $display("FAIL rst_mid_armed: got %b expected 0", bus.armed); end
      checks++; if (bus.matched !== 1'b0) begin errors++; $display("FAIL rst_mid_matched: got %b expected 0", bus.matched); end
      checks++; if (bus.match !== 1'b0 || bus.tck_edge !== 1'b0) begin errors++; $display("FAIL rst_mid_pulses: got match=%b tck_edge=%b expected 0 0", bus.match, bus.tck_edge); end
      clear_mon();
      send_word(w);
      repeat (3) tick();
      checks++; if (match_cnt !== 0) begin errors++; $display("FAIL unarmed_match: got %0d pulses expected 0", match_cnt); end
      checks++; if (bus.bit_count !== 8'd0) begin errors++; $display("FAIL unarmed_count: got %0d expected 0", bus.bit_count); end
      checks++; if (bus.armed !== 1'b0) begin errors++; $display("FAIL unarmed_armed: got %b expected 0", bus.armed); end
   endtask

   initial begin
      bus.arm     = 1'b0;
      bus.pattern = '0;
      test_reset();
      test_match();
      test_tap();
      test_sliding();
      test_arm_on_edge();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
